imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/opcode_legal.sv | 19 +
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: base opcodes and the instruction-memory loader state encoding.
package riscv_pkg;

  // RV32I major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Loader sequencing: length bytes, payload words, final write, then release or error
  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    LAST,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/opcode_legal.sv
// Flags whether a 7-bit opcode is one of the supported RV32I major opcodes.
module opcode_legal
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal
);

  // Pure lookup against the base opcode set
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: reads a 16-bit word count, then
// assembles little-endian 32-bit words and writes them to consecutive
// addresses while holding the core in reset until the load completes.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   illegal_cnt_o
);

  // Wide enough to hold both the 16-bit count and the capacity 2^ADDR_W
  localparam int CW = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;
  localparam logic [CW-1:0] ONE      = 1;
  localparam logic [CW-1:0] CAPACITY = ONE << ADDR_W;

  loader_state_t     state_reg, state_next;
  logic [7:0]        len_lo_reg;
  logic [ADDR_W-1:0] last_idx_reg;
  logic [ADDR_W-1:0] word_idx_reg;
  logic [1:0]        phase_reg;
  logic [23:0]       asm_reg;
  logic              mem_wr_en_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic [ADDR_W:0]   illegal_cnt_reg;

  logic              byte_ready;
  logic              xfer;
  logic              start_load;
  logic              word_done;
  logic              last_word;
  logic [15:0]       n_full;
  logic [CW-1:0]     n_ext;
  logic              opcode_ok;

  // The opcode of the word being completed lives in the first byte received
  opcode_legal u_opcode_legal (
    .opcode (asm_reg[6:0]),
    .legal  (opcode_ok)
  );

  assign n_full = {byte_i, len_lo_reg};
  assign n_ext  = {{(CW-16){1'b0}}, n_full};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode and state-derived handshake/status outputs
  always_comb begin
    state_next = state_reg;
    byte_ready = 1'b0;
    start_load = 1'b0;
    xfer       = 1'b0;
    word_done  = 1'b0;
    last_word  = (word_idx_reg == last_idx_reg);
    core_rst_o = 1'b1;
    done_o     = 1'b0;
    err_o      = 1'b0;

    case (state_reg)
      LEN_LO, LEN_HI, DATA: byte_ready = 1'b1;
      default:              byte_ready = 1'b0;
    endcase
    xfer      = byte_valid_i & byte_ready;
    word_done = (state_reg == DATA) && xfer && (phase_reg == 2'd3);

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_next = LEN_LO;
          start_load = 1'b1;
        end
      end
      LEN_LO: if (xfer) state_next = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (n_ext > CAPACITY)    state_next = ERR;
          else if (n_full == 16'd0) state_next = DONE;
          else                      state_next = DATA;
        end
      end
      DATA:    if (word_done && last_word) state_next = LAST;
      LAST:    state_next = DONE;
      default: state_next = IDLE;
    endcase

    if (state_reg == DONE) core_rst_o = 1'b0;
    if (state_reg == DONE) done_o     = 1'b1;
    if (state_reg == ERR)  err_o      = 1'b1;
  end

  // Length capture, word assembly, memory write port and illegal-opcode count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_lo_reg      <= '0;
      last_idx_reg    <= '0;
      word_idx_reg    <= '0;
      phase_reg       <= '0;
      asm_reg         <= '0;
      mem_wr_en_reg   <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      illegal_cnt_reg <= '0;
    end else begin
      mem_wr_en_reg <= 1'b0;
      if (start_load) begin
        illegal_cnt_reg <= '0;
        word_idx_reg    <= '0;
        phase_reg       <= '0;
      end
      if (state_reg == LEN_LO && xfer) len_lo_reg <= byte_i;
      if (state_reg == LEN_HI && xfer) last_idx_reg <= ADDR_W'(n_ext - ONE);
      if (state_reg == DATA && xfer) begin
        phase_reg <= phase_reg + 2'd1;
        // Shift in from the top so byte 0 lands in [7:0] after three bytes
        if (phase_reg != 2'd3) asm_reg <= {byte_i, asm_reg[23:8]};
      end
      if (word_done) begin
        mem_wr_en_reg <= 1'b1;
        mem_addr_reg  <= word_idx_reg;
        mem_wdata_reg <= {byte_i, asm_reg};
        word_idx_reg  <= word_idx_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (!opcode_ok) illegal_cnt_reg <= illegal_cnt_reg + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  assign byte_ready_o  = byte_ready;
  assign mem_wr_en_o   = mem_wr_en_reg;
  assign mem_addr_o    = mem_addr_reg;
  assign mem_wdata_o   = mem_wdata_reg;
  assign illegal_cnt_o = illegal_cnt_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a default-width instance and a 4-word
// instance share the byte stream; each has its own expected-write queue.
module tb_imem_loader;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start8 = 1'b0, start2 = 1'b0;
  logic bv = 1'b0;
  logic [7:0] bd = 8'h00;

  logic        rdy8, wr8, crst8, done8, err8;
  logic [7:0]  addr8;
  logic [31:0] wdata8;
  logic [8:0]  ill8;

  logic        rdy2, wr2, crst2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  ill2;

  int checks = 0;
  int passes = 0;
  int sel = 0;
  wr_t exp8[$];
  wr_t exp2[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .byte_valid_i(bv), .byte_i(bd),
    .byte_ready_o(rdy8), .mem_wr_en_o(wr8), .mem_addr_o(addr8), .mem_wdata_o(wdata8),
    .core_rst_o(crst8), .done_o(done8), .err_o(err8), .illegal_cnt_o(ill8)
  );

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .byte_valid_i(bv), .byte_i(bd),
    .byte_ready_o(rdy2), .mem_wr_en_o(wr2), .mem_addr_o(addr2), .mem_wdata_o(wdata2),
    .core_rst_o(crst2), .done_o(done2), .err_o(err2), .illegal_cnt_o(ill2)
  );

  // Write monitor for the default-width instance
  always @(negedge clk) begin
    wr_t e;
    if (wr8 === 1'b1) begin
      checks++;
      if (exp8.size() == 0) begin
        $display("FAIL wr8_unexpected got addr=%0d data=%h required no write", addr8, wdata8);
      end else begin
        e = exp8.pop_front();
        if (addr8 !== e.addr[7:0] || wdata8 !== e.data)
          $display("FAIL wr8 got addr=%0d data=%h required addr=%0d data=%h", addr8, wdata8, e.addr, e.data);
        else begin
          passes++;
          $display("write8 addr=%0d data=%h ok", addr8, wdata8);
        end
      end
    end
  end

  // Write monitor for the 4-word instance
  always @(negedge clk) begin
    wr_t e;
    if (wr2 === 1'b1) begin
      checks++;
      if (exp2.size() == 0) begin
        $display("FAIL wr2_unexpected got addr=%0d data=%h required no write", addr2, wdata2);
      end else begin
        e = exp2.pop_front();
        if (addr2 !== e.addr[1:0] || wdata2 !== e.data)
          $display("FAIL wr2 got addr=%0d data=%h required addr=%0d data=%h", addr2, wdata2, e.addr, e.data);
        else begin
          passes++;
          $display("write2 addr=%0d data=%h ok", addr2, wdata2);
        end
      end
    end
  end

  function automatic bit legal_op(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start8 = 1'b1;
    else            start2 = 1'b1;
    tick();
    start8 = 1'b0;
    start2 = 1'b0;
  endtask

  // Present one byte, optionally after a random idle gap, and hold it until accepted
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    bv = 1'b0;
    repeat (gap) tick();
    bv = 1'b1;
    bd = b;
    waited = 0;
    while (((sel == 0) ? rdy8 : rdy2) !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) begin
      checks++;
      $display("FAIL send_timeout got ready=0 required ready=1 for byte %h", b);
    end
    tick();
    bv = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    send_byte(w[7:0], max_gap);
    send_byte(w[15:8], max_gap);
    send_byte(w[23:16], max_gap);
    send_byte(w[31:24], max_gap);
  endtask

  task automatic push8(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp8.push_back(e);
  endtask

  task automatic push2(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp2.push_back(e);
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({rdy8, wr8, crst8, done8, err8} !== 5'b00100)
      $display("FAIL reset_flags got %b required 00100", {rdy8, wr8, crst8, done8, err8});
    else passes++;
    checks++;
    if (addr8 !== 8'd0 || wdata8 !== 32'd0 || ill8 !== 9'd0)
      $display("FAIL reset_regs got addr=%0d data=%h ill=%0d required 0 0 0", addr8, wdata8, ill8);
    else passes++;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rdy8 !== 1'b0 || crst8 !== 1'b1 || rdy2 !== 1'b0 || crst2 !== 1'b1)
      $display("FAIL idle_after_reset got rdy=%b crst=%b required rdy=0 crst=1", rdy8, crst8);
    else passes++;
    $display("reset done");
  endtask

  // Reference two-word program, optionally with random valid gaps
  task automatic run_two_word_load(input int max_gap);
    sel = 0;
    pulse_start(0);
    checks++;
    if (rdy8 !== 1'b1 || ill8 !== 9'd0)
      $display("FAIL start_len_lo got rdy=%b ill=%0d required rdy=1 ill=0", rdy8, ill8);
    else passes++;
    push8(0, 32'h00100093);
    push8(1, 32'h00110133);
    send_byte(8'h02, max_gap);
    send_byte(8'h00, max_gap);
    send_word(32'h00100093, max_gap);
    checks++;
    if (max_gap == 0 && (wr8 !== 1'b1 || rdy8 !== 1'b1))
      $display("FAIL ready_during_write got wr=%b rdy=%b required 1 1", wr8, rdy8);
    else if (max_gap != 0 && rdy8 !== 1'b1)
      $display("FAIL ready_between_words got rdy=%b required 1", rdy8);
    else passes++;
    send_word(32'h00110133, max_gap);
    checks++;
    if (wr8 !== 1'b1 || addr8 !== 8'd1 || done8 !== 1'b0 || crst8 !== 1'b1 || rdy8 !== 1'b0)
      $display("FAIL last_cycle got wr=%b addr=%0d done=%b crst=%b rdy=%b required 1 1 0 1 0",
               wr8, addr8, done8, crst8, rdy8);
    else passes++;
    tick();
    checks++;
    if (done8 !== 1'b1 || crst8 !== 1'b0 || wr8 !== 1'b0)
      $display("FAIL done_rise got done=%b crst=%b wr=%b required 1 0 0", done8, crst8, wr8);
    else passes++;
    checks++;
    if (ill8 !== 9'd0 || exp8.size() != 0)
      $display("FAIL two_word_tail got ill=%0d pending=%0d required 0 0", ill8, exp8.size());
    else passes++;
    $display("two-word load gap=%0d finished", max_gap);
  endtask

  task automatic test_two_words();
    run_two_word_load(0);
  endtask

  task automatic test_gaps();
    run_two_word_load(3);
  endtask

  task automatic test_zero_len();
    sel = 0;
    pulse_start(0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if (done8 !== 1'b1 || crst8 !== 1'b0)
      $display("FAIL zero_len_done got done=%b crst=%b required 1 0", done8, crst8);
    else passes++;
    repeat (3) tick();
    $display("zero-length load finished");
  endtask

  task automatic test_illegal();
    sel = 0;
    pulse_start(0);
    push8(0, 32'hFFFFFFFF);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'hFFFFFFFF, 0);
    checks++;
    if (ill8 !== 9'd1)
      $display("FAIL illegal_cnt got %0d required 1", ill8);
    else passes++;
    tick();
    checks++;
    if (done8 !== 1'b1 || exp8.size() != 0)
      $display("FAIL illegal_done got done=%b pending=%0d required 1 0", done8, exp8.size());
    else passes++;
    $display("illegal-opcode load finished ill=%0d", ill8);
  endtask

  task automatic test_mixed_opcodes();
    logic [31:0] words [6];
    logic [6:0]  tab [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
    logic [31:0] r;
    logic [6:0]  op;
    int exp_ill = 0;
    sel = 0;
    pulse_start(0);
    checks++;
    if (ill8 !== 9'd0)
      $display("FAIL illegal_clear got %0d required 0", ill8);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      if (i == 1)          op = 7'h7f;
      else if (i % 2 == 0) op = tab[$urandom_range(0, 8)];
      else                 op = r[6:0];
      words[i] = {r[31:7], op};
      if (!legal_op(op)) exp_ill++;
      push8(i, words[i]);
    end
    send_byte(8'h06, 0);
    send_byte(8'h00, 0);
    send_word(words[0], 1);
    pulse_start(0);
    checks++;
    if (rdy8 !== 1'b1 || crst8 !== 1'b1)
      $display("FAIL start_ignored got rdy=%b crst=%b required 1 1", rdy8, crst8);
    else passes++;
    for (int i = 1; i < 6; i++) send_word(words[i], 1);
    tick();
    checks++;
    if (done8 !== 1'b1 || ill8 !== 9'(exp_ill) || exp8.size() != 0)
      $display("FAIL mixed_tail got done=%b ill=%0d pending=%0d required 1 %0d 0",
               done8, ill8, exp8.size(), exp_ill);
    else passes++;
    $display("mixed-opcode load finished ill=%0d", ill8);
  endtask

  task automatic test_reset_mid_load();
    sel = 0;
    pulse_start(0);
    push8(0, 32'h00000013);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_word(32'h00000013, 0);
    send_byte(8'hB7, 0);
    send_byte(8'h00, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({rdy8, wr8, crst8, done8, err8} !== 5'b00100 || addr8 !== 8'd0 || wdata8 !== 32'd0 || ill8 !== 9'd0)
      $display("FAIL reset_mid_load got flags=%b addr=%0d data=%h ill=%0d required 00100 0 0 0",
               {rdy8, wr8, crst8, done8, err8}, addr8, wdata8, ill8);
    else passes++;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if (crst8 !== 1'b1 || rdy8 !== 1'b0 || exp8.size() != 0)
      $display("FAIL after_mid_reset got crst=%b rdy=%b pending=%0d required 1 0 0",
               crst8, rdy8, exp8.size());
    else passes++;
    $display("mid-load reset finished");
  endtask

  task automatic test_err_small();
    sel = 1;
    pulse_start(1);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    checks++;
    if (err2 !== 1'b1 || rdy2 !== 1'b0 || crst2 !== 1'b1 || done2 !== 1'b0)
      $display("FAIL too_long got err=%b rdy=%b crst=%b done=%b required 1 0 1 0", err2, rdy2, crst2, done2);
    else passes++;
    repeat (2) tick();
    pulse_start(1);
    checks++;
    if (rdy2 !== 1'b1 || err2 !== 1'b0 || crst2 !== 1'b1)
      $display("FAIL restart_from_err got rdy=%b err=%b crst=%b required 1 0 1", rdy2, err2, crst2);
    else passes++;
    $display("oversize length rejected");
  endtask

  task automatic test_boundary();
    logic [31:0] w;
    int exp_ill = 0;
    sel = 1;
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      if (i == 2) w[6:0] = 7'h6f;
      if (!legal_op(w[6:0])) exp_ill++;
      push2(i, w);
      send_word(w, 0);
    end
    checks++;
    if (wr2 !== 1'b1 || addr2 !== 2'd3)
      $display("FAIL full_last_write got wr=%b addr=%0d required 1 3", wr2, addr2);
    else passes++;
    tick();
    checks++;
    if (done2 !== 1'b1 || ill2 !== 3'(exp_ill) || exp2.size() != 0)
      $display("FAIL full_tail got done=%b ill=%0d pending=%0d required 1 %0d 0",
               done2, ill2, exp2.size(), exp_ill);
    else passes++;
    $display("full-capacity load finished");
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_illegal();
    test_mixed_opcodes();
    test_gaps();
    test_reset_mid_load();
    test_err_small();
    test_boundary();
    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
